// File: rtl/vram_arbiter_if.sv
// Signal bundle between vram_arbiter, its three requesters and the VRAM device.
// The arbiter takes the slave view; requesters and the VRAM model take the master view.
interface vram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          vid_req_i;
    logic [AW-1:0] vid_addr_i;
    logic [DW-1:0] vid_data_o;
    logic          vid_valid_o;

    logic          reg_req_i;
    logic          reg_wr_i;
    logic [AW-1:0] reg_addr_i;
    logic [DW-1:0] reg_data_i;
    logic          reg_ack_o;
    logic [DW-1:0] reg_data_o;
    logic          reg_valid_o;

    logic          blit_req_i;
    logic          blit_wr_i;
    logic [AW-1:0] blit_addr_i;
    logic [DW-1:0] blit_data_i;
    logic          blit_ack_o;
    logic [DW-1:0] blit_data_o;
    logic          blit_valid_o;

    logic          vram_sel_o;
    logic          vram_wr_o;
    logic [AW-1:0] vram_addr_o;
    logic [DW-1:0] vram_data_o;
    logic [DW-1:0] vram_data_i;
    logic          starve_o;

    modport slave (
        input  vid_req_i, vid_addr_i,
        output vid_data_o, vid_valid_o,
        input  reg_req_i, reg_wr_i, reg_addr_i, reg_data_i,
        output reg_ack_o, reg_data_o, reg_valid_o,
        input  blit_req_i, blit_wr_i, blit_addr_i, blit_data_i,
        output blit_ack_o, blit_data_o, blit_valid_o,
        output vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
        input  vram_data_i,
        output starve_o
    );

    modport master (
        output vid_req_i, vid_addr_i,
        input  vid_data_o, vid_valid_o,
        output reg_req_i, reg_wr_i, reg_addr_i, reg_data_i,
        input  reg_ack_o, reg_data_o, reg_valid_o,
        output blit_req_i, blit_wr_i, blit_addr_i, blit_data_i,
        input  blit_ack_o, blit_data_o, blit_valid_o,
        input  vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
        output vram_data_i,
        input  starve_o
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video has absolute priority, reg and blit share the
// remaining slots round-robin; read data is routed back by a tag pipeline.
module vram_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 1024
) (
    input  logic          clk,
    input  logic          reset_n_i,
    vram_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {RR_REG, RR_BLIT} rr_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_REG, TAG_BLIT} tag_e;

    rr_e           rr_last_q, rr_last_d;
    logic          sel_q, sel_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    tag_e          tag_q [RD_LAT+1];
    tag_e          tag_d [RD_LAT+1];
    logic          vid_valid_q, vid_valid_d, reg_valid_q, reg_valid_d, blit_valid_q, blit_valid_d;
    logic [DW-1:0] vid_data_q, vid_data_d, reg_data_q, reg_data_d, blit_data_q, blit_data_d;
    logic [CW-1:0] reg_cnt_q, reg_cnt_d, blit_cnt_q, blit_cnt_d;
    logic          gnt_vid, gnt_reg, gnt_blit;

    function automatic logic [CW-1:0] cnt_next(input logic req, input logic ack,
                                               input logic [CW-1:0] cnt);
        if (!req || ack) return '0;
        if (cnt == CW'(STARVE_MAX)) return cnt;
        return cnt + CW'(1);
    endfunction

    // Grants are gated by reset so no request is acknowledged while held in reset.
    always_comb begin
        gnt_vid  = 1'b0;
        gnt_reg  = 1'b0;
        gnt_blit = 1'b0;
        if (reset_n_i) begin
            if (bus.vid_req_i) begin
                gnt_vid = 1'b1;
            end else if (bus.reg_req_i && bus.blit_req_i) begin
                gnt_reg  = (rr_last_q == RR_BLIT);
                gnt_blit = !gnt_reg;
            end else begin
                gnt_reg  = bus.reg_req_i;
                gnt_blit = bus.blit_req_i;
            end
        end
    end

    always_comb begin
        sel_d     = gnt_vid || gnt_reg || gnt_blit;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rr_last_d = rr_last_q;
        tag_d[0]  = TAG_NONE;
        if (gnt_vid) begin
            addr_d   = bus.vid_addr_i;
            tag_d[0] = TAG_VID;
        end else if (gnt_reg) begin
            wr_d      = bus.reg_wr_i;
            addr_d    = bus.reg_addr_i;
            wdata_d   = bus.reg_data_i;
            rr_last_d = RR_REG;
            tag_d[0]  = bus.reg_wr_i ? TAG_NONE : TAG_REG;
        end else if (gnt_blit) begin
            wr_d      = bus.blit_wr_i;
            addr_d    = bus.blit_addr_i;
            wdata_d   = bus.blit_data_i;
            rr_last_d = RR_BLIT;
            tag_d[0]  = bus.blit_wr_i ? TAG_NONE : TAG_BLIT;
        end
        for (int i = 1; i <= RD_LAT; i++) tag_d[i] = tag_q[i-1];

        // The last tag stage lines up with the cycle vram_data_i is valid.
        vid_valid_d  = (tag_q[RD_LAT] == TAG_VID);
        reg_valid_d  = (tag_q[RD_LAT] == TAG_REG);
        blit_valid_d = (tag_q[RD_LAT] == TAG_BLIT);
        vid_data_d   = vid_valid_d  ? bus.vram_data_i : vid_data_q;
        reg_data_d   = reg_valid_d  ? bus.vram_data_i : reg_data_q;
        blit_data_d  = blit_valid_d ? bus.vram_data_i : blit_data_q;

        reg_cnt_d  = cnt_next(bus.reg_req_i, gnt_reg, reg_cnt_q);
        blit_cnt_d = cnt_next(bus.blit_req_i, gnt_blit, blit_cnt_q);
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_last_q    <= RR_BLIT;
            sel_q        <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= TAG_NONE;
            vid_valid_q  <= 1'b0;
            reg_valid_q  <= 1'b0;
            blit_valid_q <= 1'b0;
            vid_data_q   <= '0;
            reg_data_q   <= '0;
            blit_data_q  <= '0;
            reg_cnt_q    <= '0;
            blit_cnt_q   <= '0;
        end else begin
            rr_last_q    <= rr_last_d;
            sel_q        <= sel_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            tag_q        <= tag_d;
            vid_valid_q  <= vid_valid_d;
            reg_valid_q  <= reg_valid_d;
            blit_valid_q <= blit_valid_d;
            vid_data_q   <= vid_data_d;
            reg_data_q   <= reg_data_d;
            blit_data_q  <= blit_data_d;
            reg_cnt_q    <= reg_cnt_d;
            blit_cnt_q   <= blit_cnt_d;
        end
    end

    assign bus.reg_ack_o    = gnt_reg;
    assign bus.blit_ack_o   = gnt_blit;
    assign bus.vram_sel_o   = sel_q;
    assign bus.vram_wr_o    = wr_q;
    assign bus.vram_addr_o  = addr_q;
    assign bus.vram_data_o  = wdata_q;
    assign bus.vid_valid_o  = vid_valid_q;
    assign bus.vid_data_o   = vid_data_q;
    assign bus.reg_valid_o  = reg_valid_q;
    assign bus.reg_data_o   = reg_data_q;
    assign bus.blit_valid_o = blit_valid_q;
    assign bus.blit_data_o  = blit_data_q;
    assign bus.starve_o     = (reg_cnt_q == CW'(STARVE_MAX)) || (blit_cnt_q == CW'(STARVE_MAX));
endmodule
